// File: rtl/wb_demux_regbank_if.sv
// Write-back request channel: a destination-tagged result offered with valid/ready.
interface wb_demux_regbank_if #(
  parameter int unsigned DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/wb_demux_regbank.sv
// Two-entry in-order write-back queue demuxing results into four operand registers.
// Register contents feed the operand mux; pending flags expose queued destinations.
module wb_demux_regbank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned QDEPTH = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  wb_demux_regbank_if.slave   wr,
  input  logic                stall,
  input  logic                flush,
  output logic [DATA_W-1:0]   data0x,
  output logic [DATA_W-1:0]   data1x,
  output logic [DATA_W-1:0]   data2x,
  output logic [DATA_W-1:0]   data3x,
  output logic [3:0]          pending,
  output logic [1:0]          q_count
);

  localparam int unsigned NREGS = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state, state_nxt;
  entry_t            q0, q1;
  entry_t            in_entry;
  logic [DATA_W-1:0] regs [NREGS];
  logic              push, pop, do_push, do_write;

  assign in_entry    = '{sel: wr.wr_sel, data: wr.wr_data};
  assign q_count     = 2'(state);
  assign wr.wr_ready = (q_count != 2'(QDEPTH));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  // Next state and queue/register strobes; flush overrides both push and pop
  always_comb begin
    state_nxt = state;
    push      = wr.wr_valid & wr.wr_ready;
    pop       = (state != EMPTY) & ~stall;
    do_push   = push & ~flush;
    do_write  = pop & ~flush;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (pop && !push) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Queue storage and register write-back from the head entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q0 <= '0;
      q1 <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (do_write) regs[q0.sel] <= q0.data;
      if (do_push && do_write) begin
        q0 <= in_entry;
      end else if (do_push) begin
        if (state == EMPTY) q0 <= in_entry;
        else                q1 <= in_entry;
      end else if (do_write) begin
        q0 <= q1;
      end
    end
  end

  // Destinations of valid queue entries only; the incoming request is not included
  always_comb begin
    pending = '0;
    if (state != EMPTY) pending[q0.sel] = 1'b1;
    if (state == FULL)  pending[q1.sel] = 1'b1;
  end

  assign data0x = regs[0];
  assign data1x = regs[1];
  assign data2x = regs[2];
  assign data3x = regs[3];

endmodule

// File: tb/tb_wb_demux_regbank.sv
// Directed bench for wb_demux_regbank with hand-computed expectations.
module tb_wb_demux_regbank;
  localparam int unsigned DATA_W = 8;

  logic              clock;
  logic              reset_n;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] data0x, data1x, data2x, data3x;
  logic [3:0]        pending;
  logic [1:0]        q_count;
  int                total;
  int                bad;

  wb_demux_regbank_if #(.DATA_W(DATA_W)) wr ();

  wb_demux_regbank #(.DATA_W(DATA_W), .QDEPTH(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wr      (wr),
    .stall   (stall),
    .flush   (flush),
    .data0x  (data0x),
    .data1x  (data1x),
    .data2x  (data2x),
    .data3x  (data3x),
    .pending (pending),
    .q_count (q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
    wr.wr_valid = v;
    wr.wr_sel   = s;
    wr.wr_data  = d;
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, "_d0"}, 32'(data0x), 32'(e0));
    chk({tag, "_d1"}, 32'(data1x), 32'(e1));
    chk({tag, "_d2"}, 32'(data2x), 32'(e2));
    chk({tag, "_d3"}, 32'(data3x), 32'(e3));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 2'd0, 8'h00);
    tick(); tick();
    chk_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst_qc", 32'(q_count), 32'd0);
    chk("rst_pend", 32'(pending), 32'h0);
    chk("rst_rdy", 32'(wr.wr_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // 1: single write, one-edge latency
    drive(1'b1, 2'd2, 8'hA5);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    chk("t1_qc1", 32'(q_count), 32'd1);
    chk("t1_pend", 32'(pending), 32'h4);
    chk("t1_d2_before", 32'(data2x), 32'h00);
    tick();
    chk_regs("t1", 8'h00, 8'h00, 8'hA5, 8'h00);
    chk("t1_qc0", 32'(q_count), 32'd0);
    chk("t1_pend0", 32'(pending), 32'h0);

    // 2: stall fills the queue, then drain in order
    stall = 1'b1;
    drive(1'b1, 2'd0, 8'h11);
    tick();
    chk("t2_qc1", 32'(q_count), 32'd1);
    chk("t2_pend1", 32'(pending), 32'h1);
    drive(1'b1, 2'd1, 8'h22);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    chk("t2_qc2", 32'(q_count), 32'd2);
    chk("t2_rdy0", 32'(wr.wr_ready), 32'd0);
    chk("t2_pend", 32'(pending), 32'h3);
    chk_regs("t2_held", 8'h00, 8'h00, 8'hA5, 8'h00);
    stall = 1'b0;
    tick();
    chk_regs("t2_e1", 8'h11, 8'h00, 8'hA5, 8'h00);
    chk("t2_pend_e1", 32'(pending), 32'h2);
    tick();
    chk_regs("t2_e2", 8'h11, 8'h22, 8'hA5, 8'h00);
    chk("t2_qc_e2", 32'(q_count), 32'd0);

    // 3: same destination twice, later value wins
    stall = 1'b1;
    drive(1'b1, 2'd3, 8'h01);
    tick();
    drive(1'b1, 2'd3, 8'h02);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    chk("t3_pend", 32'(pending), 32'h8);
    stall = 1'b0;
    tick();
    chk("t3_d3_a", 32'(data3x), 32'h01);
    chk("t3_pend_a", 32'(pending), 32'h8);
    chk("t3_qc_a", 32'(q_count), 32'd1);
    tick();
    chk("t3_d3_b", 32'(data3x), 32'h02);
    chk("t3_pend_b", 32'(pending), 32'h0);

    // 4: steady push+pop at occupancy one
    drive(1'b1, 2'd0, 8'h33);
    tick();
    chk("t4_qc_start", 32'(q_count), 32'd1);
    drive(1'b1, 2'd1, 8'h5A);
    chk("t4_rdy0", 32'(wr.wr_ready), 32'd1);
    tick();
    chk("t4_d0", 32'(data0x), 32'h33);
    chk("t4_qc0", 32'(q_count), 32'd1);
    chk("t4_pend0", 32'(pending), 32'h2);
    drive(1'b1, 2'd1, 8'h5B);
    chk("t4_rdy1", 32'(wr.wr_ready), 32'd1);
    tick();
    chk("t4_d1_a", 32'(data1x), 32'h5A);
    chk("t4_qc1", 32'(q_count), 32'd1);
    drive(1'b1, 2'd1, 8'h5C);
    chk("t4_rdy2", 32'(wr.wr_ready), 32'd1);
    tick();
    chk("t4_d1_b", 32'(data1x), 32'h5B);
    chk("t4_qc2", 32'(q_count), 32'd1);
    drive(1'b1, 2'd1, 8'h5D);
    chk("t4_rdy3", 32'(wr.wr_ready), 32'd1);
    tick();
    chk("t4_d1_c", 32'(data1x), 32'h5C);
    chk("t4_qc3", 32'(q_count), 32'd1);
    drive(1'b0, 2'd0, 8'h00);
    tick();
    chk("t4_d1_d", 32'(data1x), 32'h5D);
    chk("t4_qc_end", 32'(q_count), 32'd0);

    // 5: flush a full queue with a competing push
    stall = 1'b1;
    drive(1'b1, 2'd2, 8'h77);
    tick();
    drive(1'b1, 2'd3, 8'h88);
    tick();
    chk("t5_qc2", 32'(q_count), 32'd2);
    drive(1'b1, 2'd0, 8'hFF);
    flush = 1'b1;
    stall = 1'b0;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'd0, 8'h00);
    chk("t5_qc0", 32'(q_count), 32'd0);
    chk("t5_pend", 32'(pending), 32'h0);
    chk_regs("t5", 8'h33, 8'h5D, 8'hA5, 8'h02);
    tick();
    chk_regs("t5_after", 8'h33, 8'h5D, 8'hA5, 8'h02);

    // 6: asynchronous reset with a full queue
    stall = 1'b1;
    drive(1'b1, 2'd0, 8'hC3);
    tick();
    drive(1'b1, 2'd1, 8'h3C);
    tick();
    drive(1'b0, 2'd0, 8'h00);
    chk("t6_qc2", 32'(q_count), 32'd2);
    stall = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_regs("t6_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t6_qc", 32'(q_count), 32'd0);
    chk("t6_rdy", 32'(wr.wr_ready), 32'd1);
    chk("t6_pend", 32'(pending), 32'h0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk_regs("t6_post", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t6_post_qc", 32'(q_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
